// File: rtl/intra_sram_sched.sv
// ---------------------------------------------------------------------------
// intra_sram_sched
// Arbitrates one read and one write requester onto an 8-bank pixel SRAM
// plus a separate top-left (TL) bank. Every SRAM-side output is registered.
// The returned read data is rotated by bank slots and handed back three
// cycles after acceptance.
//
// Ports
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   rd_*                   : read request (bank mask, row, rotation, TL) / ack
//   wr_*                   : write request (bank mask, row, data, TL) / ack
//   bStop                  : pipeline stall; it blocks new reads only
//   rAdr/wAdr(_TL)         : SRAM addresses, bank 0 in the MSBs
//   rE_n/wE_n              : active-low enables, bit 8 = TL bank
//   wData/wData_TL         : SRAM write data
//   rData/rData_TL         : SRAM read data (1-cycle latency)
//   bStop_r                : bStop delayed one cycle
//   rd_data/rd_data_tl     : rotated read data, held while rd_valid=0
//   rd_valid               : one-cycle return strobe
// ---------------------------------------------------------------------------
module intra_sram_sched #(
    parameter int bitDepth = 8,
    parameter int AW       = 8,
    parameter int AW_TL    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [7:0]            rd_mask,
    input  logic [AW-1:0]         rd_base,
    input  logic [2:0]            rd_rot,
    input  logic                  rd_tl,
    input  logic [AW_TL-1:0]      rd_tl_adr,
    output logic                  rd_ack,
    input  logic                  wr_req,
    input  logic [7:0]            wr_mask,
    input  logic [AW-1:0]         wr_base,
    input  logic [bitDepth*32-1:0] wr_data,
    input  logic                  wr_tl,
    input  logic [AW_TL-1:0]      wr_tl_adr,
    input  logic [bitDepth-1:0]   wr_tl_data,
    output logic                  wr_ack,
    input  logic                  bStop,
    output logic [AW*8-1:0]       rAdr,
    output logic [AW*8-1:0]       wAdr,
    output logic [AW_TL-1:0]      rAdr_TL,
    output logic [AW_TL-1:0]      wAdr_TL,
    output logic [bitDepth*32-1:0] wData,
    output logic [bitDepth-1:0]   wData_TL,
    output logic [8:0]            rE_n,
    output logic [8:0]            wE_n,
    output logic                  bStop_r,
    input  logic [bitDepth*32-1:0] rData,
    input  logic [bitDepth-1:0]   rData_TL,
    output logic [bitDepth*32-1:0] rd_data,
    output logic [bitDepth-1:0]   rd_data_tl,
    output logic                  rd_valid
);

    // One bank slot carries four pixels.
    localparam int BW = bitDepth * 4;

    logic                   conflict_s;
    logic                   rd_ack_s, wr_ack_s;
    logic [1:0]             cnt_q, cnt_d;
    logic [8:0]             rE_n_q, rE_n_d, wE_n_q, wE_n_d;
    logic [AW*8-1:0]        rAdr_q, rAdr_d, wAdr_q, wAdr_d;
    logic [AW_TL-1:0]       rAdr_TL_q, rAdr_TL_d, wAdr_TL_q, wAdr_TL_d;
    logic [bitDepth*32-1:0] wData_q, wData_d;
    logic [bitDepth-1:0]    wData_TL_q, wData_TL_d;
    logic                   bStop_r_q;
    logic                   v1_q, v2_q;
    logic [2:0]             rot1_q, rot1_d, rot2_q;
    logic                   rd_valid_q;
    logic [bitDepth*32-1:0] rd_data_q, rd_data_d, rot_data_s;
    logic [bitDepth-1:0]    rd_data_tl_q, rd_data_tl_d;

    // Arbitration: the write wins conflicts until the read has lost three times.
    always_comb begin
        conflict_s = rd_req & wr_req &
                     ((((rd_mask & wr_mask) != 8'd0) & (rd_base == wr_base)) |
                      (rd_tl & wr_tl & (rd_tl_adr == wr_tl_adr)));
        rd_ack_s = 1'b0;
        wr_ack_s = 1'b0;
        cnt_d    = cnt_q;
        if (rst) begin
            cnt_d = 2'd0;
        end else if (bStop) begin
            // A stalled read is not a conflict loss, so the count holds.
            wr_ack_s = wr_req;
        end else if (conflict_s) begin
            if (cnt_q == 2'd3) begin
                rd_ack_s = 1'b1;
                cnt_d    = 2'd0;
            end else begin
                wr_ack_s = 1'b1;
                cnt_d    = cnt_q + 2'd1;
            end
        end else begin
            wr_ack_s = wr_req;
            rd_ack_s = rd_req;
            if (rd_req) begin
                cnt_d = 2'd0;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Next SRAM port values; unmasked bank fields keep their last value.
    always_comb begin
        rE_n_d     = 9'h1FF;
        wE_n_d     = 9'h1FF;
        rAdr_d     = rAdr_q;
        wAdr_d     = wAdr_q;
        rAdr_TL_d  = rAdr_TL_q;
        wAdr_TL_d  = wAdr_TL_q;
        wData_d    = wData_q;
        wData_TL_d = wData_TL_q;
        for (int b = 0; b < 8; b++) begin
            if (rd_ack_s && rd_mask[b]) begin
                rE_n_d[b] = 1'b0;
                rAdr_d[(8-b)*AW-1 -: AW] = rd_base;
            end else begin
                rE_n_d[b] = 1'b1;
            end
            if (wr_ack_s && wr_mask[b]) begin
                wE_n_d[b] = 1'b0;
                wAdr_d[(8-b)*AW-1 -: AW] = wr_base;
                wData_d[(8-b)*BW-1 -: BW] = wr_data[(8-b)*BW-1 -: BW];
            end else begin
                wE_n_d[b] = 1'b1;
            end
        end
        if (rd_ack_s && rd_tl) begin
            rE_n_d[8] = 1'b0;
            rAdr_TL_d = rd_tl_adr;
        end else begin
            rE_n_d[8] = 1'b1;
        end
        if (wr_ack_s && wr_tl) begin
            wE_n_d[8]  = 1'b0;
            wAdr_TL_d  = wr_tl_adr;
            wData_TL_d = wr_tl_data;
        end else begin
            wE_n_d[8] = 1'b1;
        end
    end

    // Return path: rotate by rd_rot bank slots and hold when nothing returns.
    always_comb begin
        rot_data_s = '0;
        for (int j = 0; j < 8; j++) begin
            int src;
            src = (j + int'(rot2_q)) % 8;
            rot_data_s[(8-j)*BW-1 -: BW] = rData[(8-src)*BW-1 -: BW];
        end
        rot1_d = rd_ack_s ? rd_rot : rot1_q;
        if (v2_q) begin
            rd_data_d    = rot_data_s;
            rd_data_tl_d = rData_TL;
        end else begin
            rd_data_d    = rd_data_q;
            rd_data_tl_d = rd_data_tl_q;
        end
    end

    // State registers; reset also flushes the in-flight read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            rE_n_q       <= 9'h1FF;
            wE_n_q       <= 9'h1FF;
            rAdr_q       <= '0;
            wAdr_q       <= '0;
            rAdr_TL_q    <= '0;
            wAdr_TL_q    <= '0;
            wData_q      <= '0;
            wData_TL_q   <= '0;
            bStop_r_q    <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            rot1_q       <= 3'd0;
            rot2_q       <= 3'd0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_data_tl_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rE_n_q       <= rE_n_d;
            wE_n_q       <= wE_n_d;
            rAdr_q       <= rAdr_d;
            wAdr_q       <= wAdr_d;
            rAdr_TL_q    <= rAdr_TL_d;
            wAdr_TL_q    <= wAdr_TL_d;
            wData_q      <= wData_d;
            wData_TL_q   <= wData_TL_d;
            bStop_r_q    <= bStop;
            v1_q         <= rd_ack_s;
            v2_q         <= v1_q;
            rot1_q       <= rot1_d;
            rot2_q       <= rot1_q;
            rd_valid_q   <= v2_q;
            rd_data_q    <= rd_data_d;
            rd_data_tl_q <= rd_data_tl_d;
        end
    end

    assign rd_ack     = rd_ack_s;
    assign wr_ack     = wr_ack_s;
    assign rE_n       = rE_n_q;
    assign wE_n       = wE_n_q;
    assign rAdr       = rAdr_q;
    assign wAdr       = wAdr_q;
    assign rAdr_TL    = rAdr_TL_q;
    assign wAdr_TL    = wAdr_TL_q;
    assign wData      = wData_q;
    assign wData_TL   = wData_TL_q;
    assign bStop_r    = bStop_r_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_data_tl = rd_data_tl_q;

endmodule

// File: tb/tb_intra_sram_sched.sv
module tb_intra_sram_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req, rd_tl, wr_req, wr_tl, bStop;
    logic [7:0]   rd_mask, wr_mask;
    logic [7:0]   rd_base, wr_base;
    logic [2:0]   rd_rot;
    logic [10:0]  rd_tl_adr, wr_tl_adr;
    logic [255:0] wr_data, rData;
    logic [7:0]   wr_tl_data, rData_TL;
    logic         rd_ack, wr_ack, bStop_r, rd_valid;
    logic [63:0]  rAdr, wAdr;
    logic [10:0]  rAdr_TL, wAdr_TL;
    logic [255:0] wData, rd_data;
    logic [7:0]   wData_TL, rd_data_tl;
    logic [8:0]   rE_n, wE_n;

    int n_cmp = 0;
    int n_err = 0;

    intra_sram_sched #(.bitDepth(8), .AW(8), .AW_TL(11)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_mask(rd_mask), .rd_base(rd_base), .rd_rot(rd_rot),
        .rd_tl(rd_tl), .rd_tl_adr(rd_tl_adr), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_mask(wr_mask), .wr_base(wr_base), .wr_data(wr_data),
        .wr_tl(wr_tl), .wr_tl_adr(wr_tl_adr), .wr_tl_data(wr_tl_data), .wr_ack(wr_ack),
        .bStop(bStop),
        .rAdr(rAdr), .wAdr(wAdr), .rAdr_TL(rAdr_TL), .wAdr_TL(wAdr_TL),
        .wData(wData), .wData_TL(wData_TL), .rE_n(rE_n), .wE_n(wE_n),
        .bStop_r(bStop_r), .rData(rData), .rData_TL(rData_TL),
        .rd_data(rd_data), .rd_data_tl(rd_data_tl), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_tl = 1'b0; wr_req = 1'b0; wr_tl = 1'b0;
        bStop = 1'b0; rd_mask = 8'h00; wr_mask = 8'h00; rd_base = 8'd0; wr_base = 8'd0;
        rd_rot = 3'd0; rd_tl_adr = 11'd0; wr_tl_adr = 11'd0; wr_data = 256'd0;
        wr_tl_data = 8'h00; rData = 256'd0; rData_TL = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_rE_n", 256'(rE_n), 256'h1FF);
        chk("rst_wE_n", 256'(wE_n), 256'h1FF);
        chk("rst_rd_valid", 256'(rd_valid), 256'h0);
        chk("rst_bStop_r", 256'(bStop_r), 256'h0);
        chk("rst_rd_data", rd_data, 256'h0);
        chk("rst_rAdr", 256'(rAdr), 256'h0);

        // Single read, base 5, no rotation
        rData = 256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210;
        rd_req = 1'b1; rd_mask = 8'hFF; rd_base = 8'd5; rd_rot = 3'd0;
        #1 chk("rd1_ack", 256'(rd_ack), 256'h1);
        tick();
        rd_req = 1'b0;
        chk("rd1_rE_n", 256'(rE_n), 256'h100);
        chk("rd1_rAdr", 256'(rAdr), 256'h05050505_05050505);
        chk("rd1_rd_valid_T1", 256'(rd_valid), 256'h0);
        tick();
        chk("rd1_rE_n_idle", 256'(rE_n), 256'h1FF);
        chk("rd1_rd_valid_T2", 256'(rd_valid), 256'h0);
        tick();
        chk("rd1_rd_valid_T3", 256'(rd_valid), 256'h1);
        chk("rd1_rd_data", rd_data,
            256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210);
        rData = 256'h0;
        tick();
        chk("rd1_rd_valid_pulse", 256'(rd_valid), 256'h0);
        chk("rd1_hold", rd_data,
            256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210);

        // Rotation by 2 plus a TL read
        rData = 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007;
        rData_TL = 8'h3C;
        rd_req = 1'b1; rd_mask = 8'hFF; rd_base = 8'd1; rd_rot = 3'd2;
        rd_tl = 1'b1; rd_tl_adr = 11'd700;
        tick();
        rd_req = 1'b0; rd_tl = 1'b0;
        chk("rot_rE_n", 256'(rE_n), 256'h000);
        chk("rot_rAdr_TL", 256'(rAdr_TL), 256'd700);
        tick(); tick();
        chk("rot_rd_valid", 256'(rd_valid), 256'h1);
        chk("rot_rd_data", rd_data,
            256'h00000002_00000003_00000004_00000005_00000006_00000007_00000000_00000001);
        chk("rot_rd_data_tl", 256'(rd_data_tl), 256'h3C);
        tick();

        // Conflict held for five cycles: write, write, write, read, write
        rd_req = 1'b1; rd_mask = 8'h01; rd_base = 8'd7; rd_rot = 3'd0;
        wr_req = 1'b1; wr_mask = 8'h01; wr_base = 8'd7; wr_data = 256'h0;
        #1 chk("cf1_wr_ack", 256'(wr_ack), 256'h1);
        chk("cf1_rd_ack", 256'(rd_ack), 256'h0);
        tick();
        chk("cf1_wE_n", 256'(wE_n), 256'h1FE);
        chk("cf2_wr_ack", 256'(wr_ack), 256'h1);
        chk("cf2_rd_ack", 256'(rd_ack), 256'h0);
        tick();
        chk("cf3_wr_ack", 256'(wr_ack), 256'h1);
        chk("cf3_rd_ack", 256'(rd_ack), 256'h0);
        tick();
        chk("cf4_wr_ack", 256'(wr_ack), 256'h0);
        chk("cf4_rd_ack", 256'(rd_ack), 256'h1);
        tick();
        chk("cf4_rE_n", 256'(rE_n), 256'h1FE);
        chk("cf4_wE_n", 256'(wE_n), 256'h1FF);
        chk("cf5_wr_ack", 256'(wr_ack), 256'h1);
        chk("cf5_rd_ack", 256'(rd_ack), 256'h0);
        tick();
        chk("cf5_wE_n", 256'(wE_n), 256'h1FE);
        rd_req = 1'b0; wr_req = 1'b0;
        tick(); tick(); tick();

        // Stall with a read in flight and a concurrent write
        rd_req = 1'b1; rd_mask = 8'hFF; rd_base = 8'd3; rd_rot = 3'd0;
        rData = 256'hA5A5A5A5_5A5A5A5A_11111111_22222222_33333333_44444444_55555555_66666666;
        tick();
        bStop = 1'b1; rd_base = 8'd9;
        wr_req = 1'b1; wr_mask = 8'h0F; wr_base = 8'd4;
        wr_data = 256'hDEADBEEF_CAFEF00D_01020304_05060708_90A0B0C0_D0E0F000_12345678_9ABCDEF0;
        #1 chk("st_rd_ack", 256'(rd_ack), 256'h0);
        chk("st_wr_ack", 256'(wr_ack), 256'h1);
        chk("st_bStop_r_pre", 256'(bStop_r), 256'h0);
        tick();
        chk("st_rE_n", 256'(rE_n), 256'h1FF);
        chk("st_wE_n", 256'(wE_n), 256'h1F0);
        chk("st_wAdr", 256'(wAdr), 256'h04040404_00000000);
        chk("st_wData", wData,
            256'hDEADBEEF_CAFEF00D_01020304_05060708_00000000_00000000_00000000_00000000);
        chk("st_bStop_r1", 256'(bStop_r), 256'h1);
        chk("st_rd_ack2", 256'(rd_ack), 256'h0);
        wr_req = 1'b0;
        tick();
        chk("st_bStop_r2", 256'(bStop_r), 256'h1);
        chk("st_rE_n2", 256'(rE_n), 256'h1FF);
        chk("st_inflight_valid", 256'(rd_valid), 256'h1);
        chk("st_inflight_data", rd_data,
            256'hA5A5A5A5_5A5A5A5A_11111111_22222222_33333333_44444444_55555555_66666666);
        bStop = 1'b0;
        #1 chk("st_release_ack", 256'(rd_ack), 256'h1);
        tick();
        rd_req = 1'b0;
        chk("st_bStop_r3", 256'(bStop_r), 256'h0);
        chk("st_release_rE_n", 256'(rE_n), 256'h100);
        chk("st_release_rAdr", 256'(rAdr), 256'h09090909_09090909);
        tick(); tick(); tick();

        // TL-only write
        wr_req = 1'b1; wr_mask = 8'h00; wr_tl = 1'b1;
        wr_tl_adr = 11'd1969; wr_tl_data = 8'hA5;
        #1 chk("tl_wr_ack", 256'(wr_ack), 256'h1);
        tick();
        wr_req = 1'b0; wr_tl = 1'b0;
        chk("tl_wE_n", 256'(wE_n), 256'h0FF);
        chk("tl_wAdr_TL", 256'(wAdr_TL), 256'd1969);
        chk("tl_wData_TL", 256'(wData_TL), 256'hA5);
        tick();

        // Reset one cycle after a read is accepted
        rd_req = 1'b1; rd_mask = 8'hFF; rd_base = 8'd2;
        tick();
        rst = 1'b1; wr_req = 1'b1; wr_mask = 8'h01; wr_base = 8'd0;
        #1 chk("rr_rd_ack", 256'(rd_ack), 256'h0);
        chk("rr_wr_ack", 256'(wr_ack), 256'h0);
        tick();
        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        chk("rr_rE_n", 256'(rE_n), 256'h1FF);
        chk("rr_wE_n", 256'(wE_n), 256'h1FF);
        chk("rr_valid0", 256'(rd_valid), 256'h0);
        tick();
        chk("rr_valid1", 256'(rd_valid), 256'h0);
        tick();
        chk("rr_valid2", 256'(rd_valid), 256'h0);
        chk("rr_rd_data", rd_data, 256'h0);
        tick();
        chk("rr_valid3", 256'(rd_valid), 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
